// File: rtl/data_mem_bus_pkg.sv
// Shared address map, TCON bit layout and register decode for the MEM-stage bus.
package data_mem_bus_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TCON_W   = 3;
    localparam int unsigned LED_W    = 8;
    localparam int unsigned DIGITS_W = 12;

    localparam logic [31:0] RAM_BASE_DEF    = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;

    localparam logic [4:0] ADDR_TH      = 5'h00;
    localparam logic [4:0] ADDR_TL      = 5'h04;
    localparam logic [4:0] ADDR_TCON    = 5'h08;
    localparam logic [4:0] ADDR_LED     = 5'h0C;
    localparam logic [4:0] ADDR_DIGITS  = 5'h10;
    localparam logic [4:0] ADDR_SYSTICK = 5'h14;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    typedef enum logic [2:0] {
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_LED,
        REG_DIGITS,
        REG_SYSTICK,
        REG_NONE
    } periph_reg_e;

    // Map a word offset inside the peripheral window to its register.
    function automatic periph_reg_e decode_reg(input logic [2:0] word_off);
        periph_reg_e sel;
        case (word_off)
            ADDR_TH[4:2]:      sel = REG_TH;
            ADDR_TL[4:2]:      sel = REG_TL;
            ADDR_TCON[4:2]:    sel = REG_TCON;
            ADDR_LED[4:2]:     sel = REG_LED;
            ADDR_DIGITS[4:2]:  sel = REG_DIGITS;
            ADDR_SYSTICK[4:2]: sel = REG_SYSTICK;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/data_mem_bus_timer_periph.sv
// Reloading timer (TH/TL/TCON) with interrupt, plus a free-running systick counter.
module timer_periph
    import data_mem_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  periph_reg_e       wr_sel,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] th,
    output logic [DATA_W-1:0] tl,
    output logic [TCON_W-1:0] tcon,
    output logic [DATA_W-1:0] systick,
    output logic              irq
);

    logic wr_th;
    logic wr_tl;
    logic wr_tcon;

    assign wr_th   = wr_en && (wr_sel == REG_TH);
    assign wr_tl   = wr_en && (wr_sel == REG_TL);
    assign wr_tcon = wr_en && (wr_sel == REG_TCON);

    // Software writes to TL/TCON suppress the timer's own update that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + DATA_W'(1);
            if (tcon[TCON_EN] && !wr_tl && !wr_tcon) begin
                if (tl == '1) begin
                    tl <= th;
                    if (tcon[TCON_IE]) begin
                        tcon[TCON_IS] <= 1'b1;
                    end
                end else begin
                    tl <= tl + DATA_W'(1);
                end
            end
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end
            if (wr_tcon) begin
                tcon <= wdata[TCON_W-1:0];
            end
        end
    end

    assign irq = tcon[TCON_IS];

endmodule

// File: rtl/data_mem_bus.sv
// MEM-stage access block: decodes the ALU address to data RAM or the peripheral window.
module data_mem_bus
    import data_mem_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS     = 256,
    parameter int unsigned RAM_ADDR_BITS = 8,
    parameter logic [31:0] RAM_BASE      = RAM_BASE_DEF,
    parameter logic [31:0] PERIPH_BASE   = PERIPH_BASE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                MemRead,
    input  logic                MemWrite,
    output logic [DATA_W-1:0]   rdata,
    output logic [LED_W-1:0]    led,
    output logic [DIGITS_W-1:0] digits,
    output logic                irq
);

    localparam int unsigned RAM_TAG_LSB = RAM_ADDR_BITS + 2;

    logic [DATA_W-1:0]        ram [RAM_WORDS];
    logic                     ram_hit;
    logic                     periph_hit;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    periph_reg_e              reg_sel;
    logic                     periph_wr;
    logic [DATA_W-1:0]        th;
    logic [DATA_W-1:0]        tl;
    logic [TCON_W-1:0]        tcon;
    logic [DATA_W-1:0]        systick;
    logic                     unused_addr_lsbs;

    assign ram_hit    = (addr[31:RAM_TAG_LSB] == RAM_BASE[31:RAM_TAG_LSB]);
    assign periph_hit = !ram_hit && (addr[31:5] == PERIPH_BASE[31:5]);
    assign ram_idx    = addr[RAM_ADDR_BITS+1:2];
    assign reg_sel    = decode_reg(addr[4:2]);
    assign periph_wr  = MemWrite && periph_hit;
    assign unused_addr_lsbs = ^addr[1:0];

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led    <= '0;
            digits <= '0;
        end else if (periph_wr) begin
            if (reg_sel == REG_LED) begin
                led <= wdata[LED_W-1:0];
            end
            if (reg_sel == REG_DIGITS) begin
                digits <= wdata[DIGITS_W-1:0];
            end
        end
    end

    timer_periph u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (periph_wr),
        .wr_sel  (reg_sel),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .systick (systick),
        .irq     (irq)
    );

    // Same-cycle load path; returns pre-write state when a store hits the same address.
    always_comb begin
        rdata = '0;
        if (MemRead) begin
            if (ram_hit) begin
                rdata = ram[ram_idx];
            end else if (periph_hit) begin
                case (reg_sel)
                    REG_TH:      rdata = th;
                    REG_TL:      rdata = tl;
                    REG_TCON:    rdata = DATA_W'(tcon);
                    REG_LED:     rdata = DATA_W'(led);
                    REG_DIGITS:  rdata = DATA_W'(digits);
                    REG_SYSTICK: rdata = systick;
                    default:     rdata = '0;
                endcase
            end
        end
    end

endmodule
